imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for instruction memory: receives a framed byte stream, packs bytes
//  into 32-bit instruction words, writes them to consecutive imem addresses from 0.
//  Holds the CPU (PC and register file) in reset until a frame loads and passes checksum.
//  Sits between the host byte link and the instruction memory write port.
// PARAMETERS
//  ADDR_W   6    imem address width (matches 6-bit PC counter)
//  DEPTH    64   imem words; max loadable word count
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  in_valid      in   1       byte stream valid
//  in_data       in   8       byte stream data
//  in_ready      out  1       loader can accept a byte
//  imem_we       out  1       one-cycle instruction memory write strobe
//  imem_addr     out  ADDR_W  write address
//  imem_wd       out  32      write data (instruction word)
//  cpu_hold      out  1       drives CPU reset; high until load completes
//  done          out  1       frame loaded and checksum matched
//  error         out  1       bad count or checksum mismatch
//  words_loaded  out  7       words written so far in current frame
// BEHAVIOUR
//  Frame: [N] [4*N payload bytes, MSB first per word] [C]; N in 1..DEPTH;
//   C = XOR of N and all payload bytes.
//  Byte accepted on a clk edge where in_valid & in_ready.
//  Reset (sync, any state): state=IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wd=0,
//   cpu_hold=1, done=0, error=0, words_loaded=0, byte index=0, xor acc=0.
//   Words already written to imem are not cleared.
//  FSM:
//   IDLE  : in_ready=1. Accept N.
//           N==0 or N>DEPTH -> ERROR. Else store N, acc=N -> LOAD.
//   LOAD  : in_ready=1. Each accepted byte shifts into word reg, acc^=byte, byte idx++ (mod 4).
//           On 4th byte: next cycle imem_we=1 with imem_addr=words_loaded, imem_wd=packed
//           word; words_loaded++ in same cycle as strobe. After word N -> CHECK.
//   CHECK : in_ready=1. Accept C. C==acc -> DONE, else ERROR.
//   DONE  : in_ready=0, done=1; cpu_hold drops to 0 on the cycle done rises. Sticky until reset.
//   ERROR : in_ready=0, error=1, cpu_hold=1. Sticky until reset.
//  Latency: write strobe exactly 1 cycle after 4th byte accepted. done 1 cycle after C accepted.
//  Back-to-back bytes each cycle supported at full rate. Write pipeline never stalls
//   (4 bytes per word >= 1 cycle strobe), so in_ready never drops in IDLE/LOAD/CHECK.
//  in_valid gaps: no timeout; FSM waits indefinitely, partial word held.
//  imem_addr max = N-1 <= DEPTH-1; no wrap possible since N is bounded.
//  imem_we never asserts in IDLE, CHECK, DONE, ERROR except the trailing strobe
//   of the last word, which lands in the first CHECK cycle.
//  imem_addr/imem_wd hold last written values when imem_we=0.
// TESTING
//  N=1, bytes 12 34 56 78, C=0x01^0x12^0x34^0x56^0x78 -> one imem_we, addr 0,
//   wd 0x12345678; done=1, cpu_hold=0.
//  N=64, 256 bytes every cycle, correct C -> 64 strobes addr 0..63 each 1 cycle after
//   4th byte; words_loaded=64; done=1.
//  N=2, correct payload, C wrong -> 2 writes occur, error=1, cpu_hold=1, in_ready=0.
//  N=0 and separately N=65 -> ERROR next cycle, no imem_we ever.
//  N=2 with random in_valid gaps -> same writes and done as gap-free case.
//  reset asserted mid-LOAD after 5 bytes -> IDLE, words_loaded=0, cpu_hold=1;
//   fresh N=1 frame then loads to addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: unpacks a framed byte stream [N][4*N bytes][C]
// into 32-bit words written from address 0, and holds the CPU in reset until the frame checks out.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [6:0]        words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [6:0]        r_n;
    logic [7:0]        r_acc;
    logic [23:0]       r_word;
    logic [1:0]        r_byte_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wd;
    logic [6:0]        r_words_loaded;
    logic              r_hold;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic              w_count_ok;
    logic              w_word_done;
    logic              w_last_word;

    // NOTE: every signal assigned in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        in_ready    = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHECK);
        w_accept    = in_valid && in_ready;
        w_count_ok  = (in_data != 8'd0) && (int'(in_data) <= DEPTH);
        w_word_done = w_accept && (r_state == S_LOAD) && (r_byte_idx == 2'd3);
        w_last_word = w_word_done && ((r_words_loaded + 7'd1) == r_n);

        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_count_ok ? S_LOAD : S_ERROR;
            S_LOAD:  if (w_last_word) w_next = S_CHECK;
            S_CHECK: if (w_accept) w_next = (in_data == r_acc) ? S_DONE : S_ERROR;
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Datapath: byte packing, checksum accumulation and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n            <= '0;
            r_acc          <= '0;
            r_word         <= '0;
            r_byte_idx     <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wd           <= '0;
            r_words_loaded <= '0;
            r_hold         <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_done  <= (w_next == S_DONE);
            r_error <= (w_next == S_ERROR);
            r_hold  <= (w_next != S_DONE);

            if (w_accept && (r_state == S_IDLE) && w_count_ok) begin
                r_n   <= in_data[6:0];
                r_acc <= in_data;
            end

            if (w_accept && (r_state == S_LOAD)) begin
                r_word     <= {r_word[15:0], in_data};
                r_acc      <= r_acc ^ in_data;
                r_byte_idx <= r_byte_idx + 2'd1;
            end

            // The strobe and the word count advance together, one cycle after the 4th byte.
            if (w_word_done) begin
                r_we           <= 1'b1;
                r_addr         <= r_words_loaded[ADDR_W-1:0];
                r_wd           <= {r_word, in_data};
                r_words_loaded <= r_words_loaded + 7'd1;
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wd      = r_wd;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frames (short, full-depth, gappy), bad count,
// bad checksum and mid-frame reset, with write strobes checked against hand-built words.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [6:0]  words_loaded;

    int          tests;
    int          fails;
    int          strobes;
    int          snap;
    logic [31:0] exp_words [64];

    imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wd      (imem_wd),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each strobe is one cycle wide, so one negedge sample counts it exactly once.
    always @(negedge clk) begin
        if (imem_we === 1'b1) strobes <= strobes + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All driving happens 1 time unit after a rising edge.
    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] calc_c(input int n);
        logic [7:0] acc;
        acc = 8'(n);
        for (int w = 0; w < n; w++) acc = acc ^ exp_words[w][31:24] ^ exp_words[w][23:16]
                                              ^ exp_words[w][15:8] ^ exp_words[w][7:0];
        return acc;
    endfunction

    // Sends N, the payload from exp_words and C; checks each strobe right after its 4th byte.
    task automatic run_frame(input string tag, input int n, input logic [7:0] c, input int max_gap);
        logic [31:0] wv;
        send(8'(n), max_gap == 0 ? 0 : $urandom_range(max_gap));
        for (int w = 0; w < n; w++) begin
            wv = exp_words[w];
            for (int k = 0; k < 4; k++) begin
                send(wv[31 - 8*k -: 8], max_gap == 0 ? 0 : $urandom_range(max_gap));
                if (k == 0 && w > 0 && max_gap == 0) check({tag, " we_low_between"}, imem_we, 0);
                if (k == 3) begin
                    check({tag, " we"}, imem_we, 1);
                    check({tag, " addr"}, imem_addr, w);
                    check({tag, " wd"}, imem_wd, wv);
                    check({tag, " words_loaded"}, words_loaded, w + 1);
                end
            end
        end
        check({tag, " ready_in_check"}, in_ready, 1);
        send(c, max_gap == 0 ? 0 : $urandom_range(max_gap));
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        strobes  = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset state
        do_reset();
        check("rst in_ready", in_ready, 1);
        check("rst imem_we", imem_we, 0);
        check("rst imem_addr", imem_addr, 0);
        check("rst imem_wd", imem_wd, 0);
        check("rst cpu_hold", cpu_hold, 1);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst words_loaded", words_loaded, 0);

        // N=1, 12 34 56 78, C = 01^12^34^56^78 = 09
        snap = strobes;
        exp_words[0] = 32'h12345678;
        run_frame("n1", 1, 8'h09, 0);
        check("n1 done", done, 1);
        check("n1 cpu_hold", cpu_hold, 0);
        check("n1 in_ready", in_ready, 0);
        check("n1 error", error, 0);
        @(negedge clk);
        check("n1 strobes", strobes - snap, 1);

        // N=64 back-to-back, bytes 0..255; C = 0x40 ^ (xor of 0..255 = 0) = 0x40
        do_reset();
        snap = strobes;
        for (int w = 0; w < 64; w++)
            exp_words[w] = {8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)};
        run_frame("n64", 64, 8'h40, 0);
        check("n64 done", done, 1);
        check("n64 cpu_hold", cpu_hold, 0);
        check("n64 words_loaded", words_loaded, 64);
        check("n64 addr_hold", imem_addr, 63);
        check("n64 wd_hold", imem_wd, 32'hFCFDFEFF);
        @(negedge clk);
        check("n64 strobes", strobes - snap, 64);

        // N=2, correct payload, wrong checksum
        do_reset();
        snap = strobes;
        exp_words[0] = 32'hDEADBEEF;
        exp_words[1] = 32'h01020304;
        run_frame("badc", 2, calc_c(2) ^ 8'h01, 0);
        check("badc error", error, 1);
        check("badc cpu_hold", cpu_hold, 1);
        check("badc in_ready", in_ready, 0);
        check("badc done", done, 0);
        send(8'hFF, 0);
        check("badc sticky", error, 1);
        @(negedge clk);
        check("badc strobes", strobes - snap, 2);

        // N=0 and N=65 are rejected immediately, further bytes ignored
        do_reset();
        snap = strobes;
        send(8'd0, 0);
        check("n0 error", error, 1);
        check("n0 in_ready", in_ready, 0);
        check("n0 cpu_hold", cpu_hold, 1);
        for (int i = 0; i < 5; i++) send(8'h11, 0);
        check("n0 words_loaded", words_loaded, 0);
        do_reset();
        send(8'd65, 0);
        check("n65 error", error, 1);
        check("n65 in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) send(8'h22, 0);
        check("n65 done", done, 0);
        @(negedge clk);
        check("nbad strobes", strobes - snap, 0);

        // N=64 boundary accepted (covered above); N=2 with random in_valid gaps
        do_reset();
        snap = strobes;
        exp_words[0] = 32'hDEADBEEF;
        exp_words[1] = 32'h01020304;
        run_frame("gap", 2, calc_c(2), 3);
        check("gap done", done, 1);
        check("gap cpu_hold", cpu_hold, 0);
        check("gap error", error, 0);
        @(negedge clk);
        check("gap strobes", strobes - snap, 2);

        // Reset mid-LOAD after 5 bytes, then a fresh N=1 frame
        do_reset();
        send(8'd2, 0);
        for (int k = 0; k < 4; k++) send(8'h50 + 8'(k), 0);
        check("midrst pre words_loaded", words_loaded, 1);
        do_reset();
        check("midrst words_loaded", words_loaded, 0);
        check("midrst cpu_hold", cpu_hold, 1);
        check("midrst in_ready", in_ready, 1);
        check("midrst error", error, 0);
        exp_words[0] = 32'hAABBCCDD;
        run_frame("midrst n1", 1, 8'h01, 0);
        check("midrst done", done, 1);
        check("midrst cpu_hold_low", cpu_hold, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
